// File: rtl/sipo_pkg.sv
// Shared definitions for the sipo_deser serial receiver.
// Defining SIPO_PARITY_EN appends one even-parity bit to every frame.
package sipo_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

`ifdef SIPO_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  // The counter never holds more than WIDTH, even with the parity bit appended.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// One-entry word holding register for sipo_deser, with overrun detection.
// A completed word that cannot be stored is dropped and flagged, never overwrites.
module sipo_out_buf #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             ready,
  input  logic             clear_err,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             done,
  output logic             overrun
);

  // Handshake: a word transfers on any cycle with valid && ready. While valid is
  // high and ready low, data holds; valid falls after a transfer unless a new
  // word loads on that same edge.
  logic can_take;

  assign can_take = !valid || ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      data    <= '0;
      valid   <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load && can_take) begin
        data  <= word;
        valid <= 1'b1;
        done  <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      if (load && !can_take) begin
        overrun <= 1'b1;
      end else if (clear_err) begin
        overrun <= 1'b0;
      end
    end
  end

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    valid && !ready |=> $stable(data));

  a_done_valid: assert property (@(posedge clk) disable iff (rst)
    done |-> valid);

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out receiver: packs strobed bits into WIDTH-bit words.
// Optional even-parity frame bit and parity_err output under SIPO_PARITY_EN.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 2,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             bit_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sipo_done,
  output logic             overrun,
  input  logic             clear_err,
  output logic [0:0]       fsm_state
`ifdef SIPO_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam int FRAME = WIDTH + PAR_BITS;
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME - 1);
  localparam logic [CNT_W-1:0] DATA_BITS = CNT_W'(WIDTH);

  logic [0:0]       state;
  logic [0:0]       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_next;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_base;
  logic [WIDTH-1:0] sr_shifted;
  logic [WIDTH-1:0] sr_next;
  logic             data_bit;
  logic             frame_done;

  // frame_start realigns first, so a bit strobed with it starts the new word.
  always_comb begin
    cnt_base   = frame_start ? '0 : cnt;
    sr_base    = frame_start ? '0 : sr;
    data_bit   = bit_valid && (cnt_base < DATA_BITS);
    frame_done = bit_valid && (cnt_base == LAST_IDX);
    sr_next    = data_bit ? sr_shifted : sr_base;
    if (bit_valid) begin
      cnt_next = frame_done ? '0 : cnt_base + CNT_W'(1);
    end else begin
      cnt_next = cnt_base;
    end
    state_next = (cnt_next == '0) ? ST_IDLE : ST_SHIFT;
  end

  generate
    if (LSB_FIRST) begin : g_lsb
      assign sr_shifted = {in, sr_base[WIDTH-1:1]};
    end else begin : g_msb
      assign sr_shifted = {sr_base[WIDTH-2:0], in};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      sr    <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      sr    <= frame_done ? '0 : sr_next;
    end
  end

  assign fsm_state = state;

  sipo_out_buf #(
    .WIDTH(WIDTH)
  ) u_out_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (frame_done),
    .word     (sr_next),
    .ready    (out_ready),
    .clear_err(clear_err),
    .data     (out),
    .valid    (out_valid),
    .done     (sipo_done),
    .overrun  (overrun)
  );

`ifdef SIPO_PARITY_EN
  // The parity bit is never shifted in; it is checked against the held data bits.
  logic par_bad;

  assign par_bad = frame_done && (in != ^sr_base);

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else if (par_bad) begin
      parity_err <= 1'b1;
    end else if (clear_err) begin
      parity_err <= 1'b0;
    end
  end
`endif

  a_state_cnt: assert property (@(posedge clk) disable iff (rst)
    (state == ST_IDLE) == (cnt == '0));

  a_cnt_range: assert property (@(posedge clk) disable iff (rst)
    cnt <= LAST_IDX);

endmodule
